// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with a registered result and flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier.
module alu_pipe #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [2:0]       in_cond,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cmp,
  output logic             out_carry,
  output logic             out_err
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_PAR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_idle;
  logic             w_mul_done;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_res;
  logic             w_cmp;
  logic             w_carry;
  logic             w_err;
  logic             w_eq;
  logic             w_lt;
  logic [WIDTH:0]   w_sum;
  logic             r_rdy;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign in_ready   = r_rdy & w_idle & (~out_valid | out_ready);
  assign w_is_mul   = MUL_EN & (in_op == OP_MUL);
  assign w_sum      = {1'b0, in_a} + {1'b0, in_b};
  assign w_eq       = (in_a == in_b);
  assign w_lt       = SIGNED_CMP ? ($signed(in_a) < $signed(in_b))
                                 : (in_a < in_b);

  always_comb begin
    w_res   = '0;
    w_cmp   = 1'b0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    unique case (in_op)
      OP_ADD: {w_carry, w_res} = w_sum;
      OP_SUB: begin
        w_res   = in_a - in_b;
        w_carry = (in_a < in_b);
      end
      OP_AND: w_res = in_a & in_b;
      OP_OR:  w_res = in_a | in_b;
      OP_CMP: begin
        w_res = in_b;
        unique case (in_cond)
          3'd0:    w_cmp = w_eq;
          3'd1:    w_cmp = w_lt | w_eq;
          3'd2:    w_cmp = ~w_lt;
          3'd3:    w_cmp = ~w_eq;
          3'd4:    w_cmp = w_lt;
          3'd5:    w_cmp = ~w_lt & ~w_eq;
          default: w_cmp = 1'b0;
        endcase
      end
      OP_PAR: w_res = {{(WIDTH-1){1'b0}}, ^in_a};
      OP_MUL: w_err = ~MUL_EN;
      default: w_err = 1'b1;
    endcase
  end

  // in_ready stays low until the first clock after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rdy <= 1'b0;
    else          r_rdy <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_cmp   <= 1'b0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (w_mul_done) begin
      out_valid <= 1'b1;
      out_res   <= w_mul_res;
      out_cmp   <= 1'b0;
      out_carry <= 1'b0;
      out_err   <= 1'b0;
    end else if (w_in_xfer & ~w_is_mul) begin
      out_valid <= 1'b1;
      out_res   <= w_res;
      out_cmp   <= w_cmp;
      out_carry <= w_carry;
      out_err   <= w_err;
    end else if (w_out_xfer | w_in_xfer) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;

  assign w_idle     = (r_state == S_IDLE);
  assign w_mul_done = (r_state == S_MUL) & (r_cnt == '0);
  assign w_mul_res  = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_in_xfer & w_is_mul) w_state_nxt = S_MUL;
      S_MUL:  if (r_cnt == '0)          w_state_nxt = S_IDLE;
    endcase
  end

  // one partial product per cycle, LSB of the multiplier first
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_in_xfer & w_is_mul) begin
      r_cnt    <= CW'(WIDTH-1);
      r_mcand  <= in_a;
      r_mplier <= in_b;
      r_acc    <= '0;
    end else if (r_state == S_MUL) begin
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      r_acc    <= w_mul_res;
      r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end
`else
  assign w_idle     = 1'b1;
  assign w_mul_done = 1'b0;
  assign w_mul_res  = '0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed table, corner sequences, randomized model check.
// Builds with or without ALU_MUL_EN.
module tb_alu_pipe;
  localparam int W = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         cmp;
    logic         carry;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [2:0]   cond;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cmp;
    logic         scmp;
    logic         carry;
    logic         err;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [2:0]   in_cond;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_cmp;
  logic         out_carry;
  logic         out_err;
  logic         s_in_ready;
  logic         s_out_valid;
  logic [W-1:0] s_out_res;
  logic         s_out_cmp;
  logic         s_out_carry;
  logic         s_out_err;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b0)) u_dut (
    .clock(clk), .reset_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cmp(out_cmp),
    .out_carry(out_carry), .out_err(out_err)
  );

  alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b1)) u_sdut (
    .clock(clk), .reset_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_a(in_a), .in_b(in_b),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_res(s_out_res), .out_cmp(s_out_cmp),
    .out_carry(s_out_carry), .out_err(s_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [2:0] cond,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input bit sgn);
    exp_t   e;
    longint ua;
    longint ub;
    int     sa;
    int     sb;
    bit     lt;
    bit     eq;
    e  = '0;
    ua = longint'(a);
    ub = longint'(b);
    sa = sgn ? int'($signed(a)) : int'(a);
    sb = sgn ? int'($signed(b)) : int'(b);
    lt = (sa < sb);
    eq = (sa == sb);
    case (op)
      3'd0: begin
        e.res   = W'(ua + ub);
        e.carry = ((ua + ub) >> W) != 0;
      end
      3'd1: begin
        e.res   = W'(ua - ub);
        e.carry = (ua < ub);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: begin
        e.res = b;
        case (cond)
          3'd0:    e.cmp = eq;
          3'd1:    e.cmp = lt || eq;
          3'd2:    e.cmp = !lt;
          3'd3:    e.cmp = !eq;
          3'd4:    e.cmp = lt;
          3'd5:    e.cmp = !lt && !eq;
          default: e.cmp = 1'b0;
        endcase
      end
      3'd5: e.res = W'($countones(a) % 2);
      3'd6: begin
        if (MUL_EN) e.res = W'(ua * ub);
        else        e.err = 1'b1;
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_op    = op;
    in_cond  = 3'd0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
  endtask

  vec_t tv[17];
  int   lat;
  int   busy;
  bit   ev;
  exp_t er, es, mr, ms, e0, e1;
  int   mul_left;
  bit   rdy;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_cond = '0; in_a = '0; in_b = '0;

    tv[0]  = '{3'd0, 3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{3'd1, 3'd0, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{3'd1, 3'd0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[3]  = '{3'd4, 3'd4, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{3'd2, 3'd0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{3'd3, 3'd0, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{3'd5, 3'd0, 16'h0007, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{3'd5, 3'd0, 16'h0003, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{3'd4, 3'd0, 16'h0005, 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{3'd4, 3'd6, 16'h0005, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{3'd4, 3'd5, 16'h8000, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[11] = '{3'd7, 3'd0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[12] = '{3'd4, 3'd1, 16'h0003, 16'h0007, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[13] = '{3'd4, 3'd2, 16'h0003, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[14] = '{3'd4, 3'd3, 16'h0003, 16'h0007, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[15] = '{3'd4, 3'd2, 16'hFFFF, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[16] = '{3'd6, 3'd0, 16'd300, 16'd300,
               (MUL_EN ? 16'h5F90 : 16'h0000), 1'b0, 1'b0, 1'b0, !MUL_EN};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_res", out_res, 0);
    chk("rst_flags", {out_cmp, out_carry, out_err}, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_before_clk", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_after_clk", in_ready, 1);

    // directed table
    for (int i = 0; i < 17; i++) begin
      in_op = tv[i].op; in_cond = tv[i].cond;
      in_a = tv[i].a; in_b = tv[i].b;
      in_valid = 1'b1; out_ready = 1'b1;
      #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1; busy = 0;
      while (!out_valid && lat < 40) begin
        if (!in_ready) busy++;
        @(negedge clk);
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat,
          (MUL_EN && tv[i].op == 3'd6) ? W + 1 : 1);
      chk($sformatf("v%0d_stall", i), busy,
          (MUL_EN && tv[i].op == 3'd6) ? W : 0);
      chk($sformatf("v%0d_res", i), out_res, tv[i].res);
      chk($sformatf("v%0d_cmp", i), out_cmp, tv[i].cmp);
      chk($sformatf("v%0d_scmp", i), s_out_cmp, tv[i].scmp);
      chk($sformatf("v%0d_carry", i), out_carry, tv[i].carry);
      chk($sformatf("v%0d_err", i), out_err, tv[i].err);
    end

    // back-to-back SUB at full throughput
    drain();
    drive(3'd1, 16'd5, 16'd3);
    #1 chk("b2b_ready0", in_ready, 1);
    @(negedge clk);
    chk("b2b_res0", out_res, 16'h0002);
    chk("b2b_carry0", out_carry, 0);
    drive(3'd1, 16'd3, 16'd5);
    #1 chk("b2b_ready1", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid1", out_valid, 1);
    chk("b2b_res1", out_res, 16'hFFFE);
    chk("b2b_carry1", out_carry, 1);

    // backpressure: hold, then simultaneous in/out transfer
    drain();
    out_ready = 1'b0;
    drive(3'd0, 16'd1, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_res", k), out_res, 16'h0002);
      chk($sformatf("hold%0d_ready", k), in_ready, 0);
      @(negedge clk);
    end
    drive(3'd0, 16'd3, 16'd4);
    out_ready = 1'b1;
    #1 chk("swap_in_ready", in_ready, 1);
    chk("swap_old_res", out_res, 16'h0002);
    @(negedge clk);
    in_valid = 1'b0;
    chk("swap_valid", out_valid, 1);
    chk("swap_new_res", out_res, 16'h0007);
    @(negedge clk);
    chk("swap_cleared", out_valid, 0);

    // reset in the middle of a MUL / with a held result
    drain();
`ifdef ALU_MUL_EN
    drive(3'd6, 16'd300, 16'd300);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
`else
    out_ready = 1'b0;
    drive(3'd0, 16'd1, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("prerst_valid", out_valid, 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_res", out_res, 0);
    chk("midrst_flags", {out_cmp, out_carry, out_err}, 0);
    chk("midrst_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    drive(3'd0, 16'd2, 16'd2);
    #1 chk("postrst_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("postrst_valid", out_valid, 1);
    chk("postrst_res", out_res, 16'h0004);
    repeat (20) @(negedge clk);
    chk("postrst_no_stale", out_valid, 0);

    // randomized traffic against the behavioural model
    drain();
    ev = 1'b0; mul_left = 0;
    er = '0; es = '0; mr = '0; ms = '0;
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_cond   = 3'($urandom_range(0, 7));
      in_a      = rnd_val();
      in_b      = rnd_val();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      rdy = (mul_left == 0) && (!ev || out_ready);
      chk("rnd_in_ready", in_ready, rdy);
      chk("rnd_s_in_ready", s_in_ready, rdy);
      chk("rnd_valid", out_valid, ev);
      chk("rnd_s_valid", s_out_valid, ev);
      if (ev) begin
        chk("rnd_res", out_res, er.res);
        chk("rnd_flags", {out_cmp, out_carry, out_err},
            {er.cmp, er.carry, er.err});
        chk("rnd_s_res", s_out_res, es.res);
        chk("rnd_s_flags", {s_out_cmp, s_out_carry, s_out_err},
            {es.cmp, es.carry, es.err});
      end
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          ev = 1'b1; er = mr; es = ms;
        end
      end else if (in_valid && rdy) begin
        e0 = model(in_op, in_cond, in_a, in_b, 1'b0);
        e1 = model(in_op, in_cond, in_a, in_b, 1'b1);
        if (MUL_EN && in_op == 3'd6) begin
          mul_left = W; ev = 1'b0; mr = e0; ms = e1;
        end else begin
          ev = 1'b1; er = e0; es = e1;
        end
      end else if (ev && out_ready) begin
        ev = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
